// File: rtl/octree_pkg.sv
// Shared types and helpers for the octree node store:
// field widths, write modes, FSM encoding and field masks.
package octree_pkg;

   localparam int PTR_W_DEF  = 16;
   localparam int MASK_W_DEF = 8;
   localparam int DEPTH_DEF  = 256;
   localparam int MAX_W      = 64;

   typedef logic [MAX_W-1:0] word_max_t;

   localparam logic [1:0] WR_OVERWRITE = 2'b00;
   localparam logic [1:0] WR_MERGE     = 2'b01;
   localparam logic [1:0] WR_PTR       = 2'b10;
   localparam logic [1:0] WR_NOP       = 2'b11;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FLUSH = 2'd1;
   localparam logic [1:0] ST_CLEAR = 2'd2;

   function automatic word_max_t ptr_mask(
      input int ptr_w,
      input int mask_w
   );
      return ((word_max_t'(1) << ptr_w) - word_max_t'(1))
             << (2 * mask_w);
   endfunction

   // leaf and branch sit side by side, so one OR covers both
   function automatic word_max_t lb_mask(
      input int mask_w
   );
      return (word_max_t'(1) << (2 * mask_w)) - word_max_t'(1);
   endfunction

   function automatic word_max_t merge_word(
      input logic [1:0] mode,
      input word_max_t  old_w,
      input word_max_t  new_w,
      input int         ptr_w,
      input int         mask_w
   );
      word_max_t pm;
      word_max_t lm;
      pm = ptr_mask(ptr_w, mask_w);
      lm = lb_mask(mask_w);
      case (mode)
         WR_OVERWRITE: return new_w;
         WR_MERGE:     return (old_w & pm) | ((old_w | new_w) & lm);
         WR_PTR:       return (new_w & pm) | (old_w & lm);
         default:      return old_w;
      endcase
   endfunction

endpackage

// File: rtl/octree_node_ram_1w2r.sv
// Plain node storage: one synchronous write port and two
// registered read ports; read-during-write returns old data.
module octree_node_ram_1w2r #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 256,
   localparam int ADDRW = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_we,
   input  logic [ADDRW-1:0] i_waddr,
   input  logic [WIDTH-1:0] i_wdata,
   input  logic             i_ra_en,
   input  logic [ADDRW-1:0] i_ra_addr,
   output logic [WIDTH-1:0] o_ra_data,
   input  logic             i_rb_en,
   input  logic [ADDRW-1:0] i_rb_addr,
   output logic [WIDTH-1:0] o_rb_data
);

   logic [WIDTH-1:0] r_mem [DEPTH];

   always_ff @(posedge i_clk) begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      if (i_ra_en) o_ra_data <= r_mem[i_ra_addr];
      if (i_rb_en) o_rb_data <= r_mem[i_rb_addr];
   end

endmodule

// File: rtl/octree_node_mem.sv
// Octree node store: RMW write pipeline with forwarding,
// write-first read bypass and a hardware clear sweep.
module octree_node_mem
   import octree_pkg::*;
#(
   parameter int PTR_W  = PTR_W_DEF,
   parameter int MASK_W = MASK_W_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   localparam int ADDRW  = $clog2(DEPTH),
   localparam int WORD_W = PTR_W + 2 * MASK_W
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_clear,
   output logic              o_busy,
   input  logic              i_wr_valid,
   output logic              o_wr_ready,
   input  logic [1:0]        i_wr_mode,
   input  logic [ADDRW-1:0]  i_wr_addr,
   input  logic [WORD_W-1:0] i_wr_data,
   input  logic              i_rd_valid,
   output logic              o_rd_ready,
   input  logic [ADDRW-1:0]  i_rd_addr,
   output logic              o_rd_valid,
   output logic [WORD_W-1:0] o_rd_data
);

   logic [1:0]        r_state;
   logic [ADDRW-1:0]  r_clr_cnt;
   logic              r_s2_valid;
   logic [1:0]        r_s2_mode;
   logic [ADDRW-1:0]  r_s2_addr;
   logic [WORD_W-1:0] r_s2_data;
   logic              r_fwd;
   logic [WORD_W-1:0] r_fwd_data;
   logic              r_rd_valid;
   logic              r_rd_has;
   logic              r_rd_byp;
   logic [WORD_W-1:0] r_rd_byp_data;

   logic              w_idle;
   logic              w_wr_fire;
   logic              w_rd_fire;
   logic              w_clearing;
   logic              w_clr_last;
   logic              w_commit;
   logic [WORD_W-1:0] w_old;
   logic [WORD_W-1:0] w_new;
   logic              w_ram_we;
   logic [ADDRW-1:0]  w_ram_waddr;
   logic [WORD_W-1:0] w_ram_wdata;
   logic [WORD_W-1:0] w_rmw_q;
   logic [WORD_W-1:0] w_rd_q;

   assign w_idle     = (r_state == ST_IDLE);
   assign w_clearing = (r_state == ST_CLEAR);
   assign w_wr_fire  = i_wr_valid && w_idle;
   assign w_rd_fire  = i_rd_valid && w_idle;
   assign w_clr_last = (r_clr_cnt == ADDRW'(DEPTH - 1));

   assign o_busy     = !w_idle;
   assign o_wr_ready = w_idle;
   assign o_rd_ready = w_idle;
   assign o_rd_valid = r_rd_valid;

   // array read missed the commit of the previous cycle
   assign w_old    = r_fwd ? r_fwd_data : w_rmw_q;
   assign w_new    = WORD_W'(merge_word(r_s2_mode,
                        word_max_t'(w_old),
                        word_max_t'(r_s2_data),
                        PTR_W, MASK_W));
   assign w_commit = r_s2_valid && (r_s2_mode != WR_NOP);

   assign w_ram_we    = w_commit || w_clearing;
   assign w_ram_waddr = w_clearing ? r_clr_cnt : r_s2_addr;
   assign w_ram_wdata = w_clearing ? '0 : w_new;

   assign o_rd_data = !r_rd_has ? '0 :
                      r_rd_byp ? r_rd_byp_data : w_rd_q;

   octree_node_ram_1w2r #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .i_clk     (i_clk),
      .i_we      (w_ram_we),
      .i_waddr   (w_ram_waddr),
      .i_wdata   (w_ram_wdata),
      .i_ra_en   (w_wr_fire),
      .i_ra_addr (i_wr_addr),
      .o_ra_data (w_rmw_q),
      .i_rb_en   (w_rd_fire),
      .i_rb_addr (i_rd_addr),
      .o_rb_data (w_rd_q)
   );

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_clr_cnt <= '0;
      end else begin
         unique case (r_state)
            ST_IDLE: if (i_clear) r_state <= ST_FLUSH;
            ST_FLUSH: r_state <= ST_CLEAR;
            ST_CLEAR: begin
               if (w_clr_last) begin
                  r_state   <= ST_IDLE;
                  r_clr_cnt <= '0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + ADDRW'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s2_valid    <= 1'b0;
         r_s2_mode     <= WR_NOP;
         r_s2_addr     <= '0;
         r_s2_data     <= '0;
         r_fwd         <= 1'b0;
         r_fwd_data    <= '0;
         r_rd_valid    <= 1'b0;
         r_rd_has      <= 1'b0;
         r_rd_byp      <= 1'b0;
         r_rd_byp_data <= '0;
      end else begin
         r_s2_valid <= w_wr_fire;
         r_rd_valid <= w_rd_fire;
         if (w_wr_fire) begin
            r_s2_mode  <= i_wr_mode;
            r_s2_addr  <= i_wr_addr;
            r_s2_data  <= i_wr_data;
            r_fwd      <= w_commit && (r_s2_addr == i_wr_addr);
            r_fwd_data <= w_new;
         end
         if (w_rd_fire) begin
            r_rd_has      <= 1'b1;
            r_rd_byp      <= w_commit && (r_s2_addr == i_rd_addr);
            r_rd_byp_data <= w_new;
         end
      end
   end

endmodule
